// File: rtl/mfp_ahb_trace_monitor.sv
// Passive AHB-Lite snooper: captures completed transfers into a circular trace buffer
// with address triggers, a post-trigger window, a free-running cycle counter and an idle watchdog.
module mfp_ahb_trace_monitor #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_LOG2   = 6,
  parameter int N_MATCH      = 2,
  parameter int STAMP_WIDTH  = 16,
  parameter int POST_TRIGGER = 8,
  parameter int TIMEOUT      = 10000
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [ADDR_WIDTH-1:0]         HADDR,
  input  logic [1:0]                    HTRANS,
  input  logic                          HWRITE,
  input  logic                          HREADY,
  input  logic [DATA_WIDTH-1:0]         HRDATA,
  input  logic [DATA_WIDTH-1:0]         HWDATA,
  input  logic                          arm,
  input  logic [N_MATCH*ADDR_WIDTH-1:0] match_addr,
  input  logic [N_MATCH-1:0]            match_en,
  input  logic                          rd_en,
  input  logic [DEPTH_LOG2-1:0]         rd_idx,
  output logic                          rd_valid,
  output logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_write,
  output logic [STAMP_WIDTH-1:0]        rd_stamp,
  output logic [1:0]                    state,
  output logic [N_MATCH-1:0]            trigger_hit,
  output logic [DEPTH_LOG2:0]           count,
  output logic                          timeout,
  output logic [31:0]                   cycle
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH + 1 + STAMP_WIDTH;
  localparam int PC_W    = (POST_TRIGGER > 0) ? $clog2(POST_TRIGGER + 1) : 1;
  localparam int IDLE_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [31:0]             r_cycle;
  logic                    r_pending;
  logic [ADDR_WIDTH-1:0]   r_ph_addr;
  logic                    r_ph_write;
  logic [N_MATCH-1:0]      r_ph_hit;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic [N_MATCH-1:0]      r_trig;
  logic                    r_timeout;
  logic [IDLE_W-1:0]       r_idle;
  logic [PC_W-1:0]         r_post;
  logic                    r_rd_valid;
  logic                    r_rd_seen;
  logic [ENTRY_W-1:0]      r_rd_word;
  logic [ENTRY_W-1:0]      r_mem [DEPTH];

  logic [N_MATCH-1:0]      w_hit;
  logic                    w_addr_phase;
  logic                    w_data_done;
  logic                    w_cap_state;
  logic                    w_capture;
  logic                    w_trig;
  logic                    w_post_last;
  logic                    w_idle_fire;
  logic [ENTRY_W-1:0]      w_entry;
  logic [DEPTH_LOG2-1:0]   w_rd_phys;
  logic                    w_rd_ok;
  logic                    w_unused;

  assign w_unused = HTRANS[0];

  genvar gi;
  generate
    for (gi = 0; gi < N_MATCH; gi++) begin : g_match
      assign w_hit[gi] = match_en[gi] && (HADDR == match_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  endgenerate

  assign w_addr_phase = HREADY & HTRANS[1];
  assign w_data_done  = r_pending & HREADY;
  // A completion in the arm cycle belongs to the previous capture session and is dropped.
  assign w_capture    = w_data_done & w_cap_state & ~arm;
  assign w_trig       = (r_state == S_ARMED) && w_capture && (|r_ph_hit);
  assign w_post_last  = (r_state == S_POST) && w_capture && (r_post == PC_W'(POST_TRIGGER - 1));
  assign w_idle_fire  = (TIMEOUT != 0) && w_cap_state && !w_capture && !arm &&
                        (r_idle == IDLE_W'(TIMEOUT - 1));
  assign w_entry      = {r_ph_addr, (r_ph_write ? HWDATA : HRDATA), r_ph_write,
                         r_cycle[STAMP_WIDTH-1:0]};

  // FSM: state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    if (arm) begin
      w_state_next = S_ARMED;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (w_idle_fire)  w_state_next = S_DONE;
          else if (w_trig)  w_state_next = (POST_TRIGGER == 0) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (w_idle_fire || w_post_last) w_state_next = S_DONE;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    w_cap_state = 1'b0;
    case (r_state)
      S_ARMED, S_POST: w_cap_state = 1'b1;
      default:         w_cap_state = 1'b0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_cycle <= '0;
    else          r_cycle <= r_cycle + 32'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_pending  <= 1'b0;
      r_ph_addr  <= '0;
      r_ph_write <= 1'b0;
      r_ph_hit   <= '0;
    end else begin
      if (w_addr_phase) begin
        r_ph_addr  <= HADDR;
        r_ph_write <= HWRITE;
        r_ph_hit   <= w_hit;
      end
      if (arm)               r_pending <= 1'b0;
      else if (w_addr_phase) r_pending <= 1'b1;
      else if (w_data_done)  r_pending <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_trig    <= '0;
      r_timeout <= 1'b0;
      r_post    <= '0;
    end else if (arm) begin
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_trig    <= '0;
      r_timeout <= 1'b0;
      r_post    <= '0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count != FULL) r_count <= r_count + 1'b1;
        r_trig <= r_trig | r_ph_hit;
      end
      if (w_trig)                                  r_post <= '0;
      else if ((r_state == S_POST) && w_capture)   r_post <= r_post + 1'b1;
      if (w_idle_fire) r_timeout <= 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                                          r_idle <= '0;
    else if (arm || !w_cap_state || w_capture || w_idle_fire) r_idle <= '0;
    else if (TIMEOUT != 0)                                 r_idle <= r_idle + 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (w_capture) r_mem[r_wr_ptr] <= w_entry;
  end

  // Index is taken from the pre-capture pointer/count; the RAM returns the old word on a collision.
  assign w_rd_phys = r_wr_ptr - r_count[DEPTH_LOG2-1:0] + rd_idx;
  assign w_rd_ok   = rd_en && ({1'b0, rd_idx} < r_count);

  always_ff @(posedge HCLK) begin
    if (w_rd_ok) r_rd_word <= r_mem[w_rd_phys];
  end

  // The RAM output register has no reset; r_rd_seen forces the visible fields to zero until a read lands.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rd_valid <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) r_rd_seen <= 1'b1;
    end
  end

  assign {rd_addr, rd_data, rd_write, rd_stamp} = r_rd_seen ? r_rd_word : '0;
  assign rd_valid    = r_rd_valid;
  assign state       = r_state;
  assign trigger_hit = r_trig;
  assign count       = r_count;
  assign timeout     = r_timeout;
  assign cycle       = r_cycle;

endmodule

// File: tb/tb_mfp_ahb_trace_monitor.sv
// Bench for mfp_ahb_trace_monitor: two instances on one snooped bus, checked every cycle
// against a list-based trace model, plus directed scenarios with literal expectations.
module tb_mfp_ahb_trace_monitor;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic [31:0] HWDATA;
  logic        arm;
  logic [63:0] match_addr;
  logic [1:0]  match_en;
  logic        rd_en;
  logic [2:0]  rd_idx;

  logic        o0_rv, o1_rv;
  logic [31:0] o0_ra, o1_ra, o0_rd, o1_rd;
  logic        o0_rw, o1_rw;
  logic [15:0] o0_rs, o1_rs;
  logic [1:0]  o0_st, o1_st, o0_hit, o1_hit;
  logic [3:0]  o0_cnt;
  logic [2:0]  o1_cnt;
  logic        o0_to, o1_to;
  logic [31:0] o0_cyc, o1_cyc;

  mfp_ahb_trace_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(3), .N_MATCH(2),
    .STAMP_WIDTH(16), .POST_TRIGGER(3), .TIMEOUT(20)
  ) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HREADY(HREADY), .HRDATA(HRDATA), .HWDATA(HWDATA), .arm(arm),
    .match_addr(match_addr), .match_en(match_en), .rd_en(rd_en), .rd_idx(rd_idx),
    .rd_valid(o0_rv), .rd_addr(o0_ra), .rd_data(o0_rd), .rd_write(o0_rw), .rd_stamp(o0_rs),
    .state(o0_st), .trigger_hit(o0_hit), .count(o0_cnt), .timeout(o0_to), .cycle(o0_cyc)
  );

  mfp_ahb_trace_monitor #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(2), .N_MATCH(2),
    .STAMP_WIDTH(16), .POST_TRIGGER(0), .TIMEOUT(0)
  ) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HREADY(HREADY), .HRDATA(HRDATA), .HWDATA(HWDATA), .arm(arm),
    .match_addr(match_addr), .match_en(match_en), .rd_en(rd_en), .rd_idx(rd_idx[1:0]),
    .rd_valid(o1_rv), .rd_addr(o1_ra), .rd_data(o1_rd), .rd_write(o1_rw), .rd_stamp(o1_rs),
    .state(o1_st), .trigger_hit(o1_hit), .count(o1_cnt), .timeout(o1_to), .cycle(o1_cyc)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: trace kept as an oldest-first list ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic [15:0] s;
  } ent_t;

  ent_t        m_buf [2][8];
  int          m_len [2];
  int          m_state [2];
  logic [1:0]  m_hit [2];
  logic        m_to [2];
  int          m_idle [2];
  int          m_post [2];
  logic        m_rv [2];
  ent_t        m_rent [2];
  logic [31:0] m_cycle;
  logic        m_pend;
  logic [31:0] m_paddr;
  logic        m_pwrite;
  logic [1:0]  m_phit;

  function automatic int p_dep(input int k);  return (k == 0) ? 8 : 4;  endfunction
  function automatic int p_pt(input int k);   return (k == 0) ? 3 : 0;  endfunction
  function automatic int p_to(input int k);   return (k == 0) ? 20 : 0; endfunction

  initial forever begin
    @(posedge HCLK or negedge HRESETn);
    if (!HRESETn) begin
      for (int k = 0; k < 2; k++) begin
        m_len[k] = 0; m_state[k] = 0; m_hit[k] = 0; m_to[k] = 0;
        m_idle[k] = 0; m_post[k] = 0; m_rv[k] = 0; m_rent[k] = '0;
      end
      m_cycle = 0; m_pend = 0; m_paddr = 0; m_pwrite = 0; m_phit = 0;
    end else begin
      automatic logic comp = m_pend && HREADY;
      for (int k = 0; k < 2; k++) begin
        automatic int idx = (k == 0) ? int'(rd_idx) : int'(rd_idx[1:0]);
        automatic ent_t e;
        if (rd_en && idx < m_len[k]) begin
          m_rv[k] = 1; m_rent[k] = m_buf[k][idx];
        end else begin
          m_rv[k] = 0;
        end
        if (arm) begin
          m_len[k] = 0; m_hit[k] = 0; m_to[k] = 0; m_idle[k] = 0; m_post[k] = 0; m_state[k] = 1;
        end else if (m_state[k] == 1 || m_state[k] == 2) begin
          if (comp) begin
            e.a = m_paddr; e.d = m_pwrite ? HWDATA : HRDATA; e.w = m_pwrite; e.s = m_cycle[15:0];
            if (m_len[k] < p_dep(k)) begin
              m_buf[k][m_len[k]] = e; m_len[k]++;
            end else begin
              for (int j = 0; j < p_dep(k) - 1; j++) m_buf[k][j] = m_buf[k][j+1];
              m_buf[k][p_dep(k)-1] = e;
            end
            m_idle[k] = 0;
            m_hit[k] = m_hit[k] | m_phit;
            if (m_state[k] == 1) begin
              if (m_phit != 0) begin
                if (p_pt(k) == 0) m_state[k] = 3;
                else begin m_state[k] = 2; m_post[k] = 0; end
              end
            end else begin
              m_post[k]++;
              if (m_post[k] == p_pt(k)) m_state[k] = 3;
            end
          end else if (p_to(k) != 0) begin
            m_idle[k]++;
            if (m_idle[k] == p_to(k)) begin m_to[k] = 1; m_state[k] = 3; m_idle[k] = 0; end
          end
        end
      end
      if (arm) m_pend = 0;
      else if (HREADY && HTRANS[1]) begin
        m_pend = 1; m_paddr = HADDR; m_pwrite = HWRITE;
        m_phit[0] = match_en[0] && (HADDR == match_addr[31:0]);
        m_phit[1] = match_en[1] && (HADDR == match_addr[63:32]);
      end else if (comp) m_pend = 0;
      m_cycle = m_cycle + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic chk_inst(input int k, input logic [1:0] st, input logic [1:0] hit,
                          input logic [31:0] cnt, input logic to, input logic [31:0] cyc,
                          input logic rv, input logic [31:0] ra, input logic [31:0] rdd,
                          input logic rw, input logic [15:0] rs);
    check($sformatf("i%0d_state", k), st, m_state[k]);
    check($sformatf("i%0d_hit", k), hit, m_hit[k]);
    check($sformatf("i%0d_count", k), cnt, m_len[k]);
    check($sformatf("i%0d_timeout", k), to, m_to[k]);
    check($sformatf("i%0d_cycle", k), cyc, m_cycle);
    check($sformatf("i%0d_rd_valid", k), rv, m_rv[k]);
    check($sformatf("i%0d_rd_addr", k), ra, m_rent[k].a);
    check($sformatf("i%0d_rd_data", k), rdd, m_rent[k].d);
    check($sformatf("i%0d_rd_write", k), rw, m_rent[k].w);
    check($sformatf("i%0d_rd_stamp", k), rs, m_rent[k].s);
  endtask

  always @(negedge HCLK) begin
    if (chk_en) begin
      chk_inst(0, o0_st, o0_hit, 32'(o0_cnt), o0_to, o0_cyc, o0_rv, o0_ra, o0_rd, o0_rw, o0_rs);
      chk_inst(1, o1_st, o1_hit, 32'(o1_cnt), o1_to, o1_cyc, o1_rv, o1_ra, o1_rd, o1_rw, o1_rs);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input int waits);
    HTRANS = 2'b10; HADDR = a; HWRITE = w; HREADY = 1'b1;
    tick();
    HTRANS = 2'b00; HADDR = 32'h0;
    for (int i = 0; i < waits; i++) begin HREADY = 1'b0; tick(); end
    HREADY = 1'b1;
    if (w) HWDATA = d; else HRDATA = d;
    tick();
  endtask

  task automatic read0(input logic [2:0] idx);
    rd_en = 1'b1; rd_idx = idx; tick(); rd_en = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_stamp;
    int quiet;
    HRESETn = 1'b0; HADDR = 0; HTRANS = 0; HWRITE = 0; HREADY = 1; HRDATA = 0; HWDATA = 0;
    arm = 0; match_addr = 0; match_en = 0; rd_en = 0; rd_idx = 0;
    repeat (3) @(posedge HCLK);
    #1;
    check("reset_state", o0_st, 0);
    check("reset_count", o0_cnt, 0);
    check("reset_cycle", o0_cyc, 0);
    check("reset_rd_valid", o0_rv, 0);
    HRESETn = 1'b1; chk_en = 1;
    tick();
    $display("[TB] reset released, cycle=%0d", o0_cyc);

    // five single writes
    pulse_arm();
    for (int i = 0; i < 5; i++) xfer(32'h10 + 32'(4*i), 1'b1, 32'hA0 + 32'(i), 0);
    check("wr5_count0", o0_cnt, 5);
    check("wr5_state0", o0_st, 1);
    check("wr5_count1_sat", o1_cnt, 4);
    read0(3'd0);
    check("wr5_rv0", o0_rv, 1);
    check("wr5_addr0", o0_ra, 32'h10);
    check("wr5_data0", o0_rd, 32'hA0);
    check("wr5_write0", o0_rw, 1);
    check("wr5_addr1_wrap", o1_ra, 32'h14);
    check("wr5_data1_wrap", o1_rd, 32'hA1);
    $display("[TB] txn: 5 writes, count0=%0d count1=%0d rd_addr0=%h", o0_cnt, o1_cnt, o0_ra);
    read0(3'd6);
    check("wr5_oob_rv0", o0_rv, 0);
    check("wr5_oob_hold0", o0_ra, 32'h10);

    // single-comparator trigger with post window
    match_addr = {32'h0, 32'h1fc00058}; match_en = 2'b01;
    pulse_arm();
    xfer(32'h1fc00058, 1'b1, 32'hC0, 0);
    check("trg_state0_post", o0_st, 2);
    check("trg_hit0", o0_hit, 2'b01);
    check("trg_state1_done", o1_st, 3);
    for (int i = 0; i < 5; i++) begin
      xfer(32'h200 + 32'(4*i), 1'b0, 32'hD0 + 32'(i), 0);
      if (i == 1) check("trg_state0_still_post", o0_st, 2);
      if (i == 2) check("trg_state0_done", o0_st, 3);
    end
    check("trg_count0", o0_cnt, 4);
    check("trg_count1", o1_cnt, 1);
    $display("[TB] txn: trigger, state0=%0d count0=%0d hit0=%b", o0_st, o0_cnt, o0_hit);

    // both comparators on the same address
    match_addr = {32'h1fc00058, 32'h1fc00058}; match_en = 2'b11;
    pulse_arm();
    xfer(32'h1fc00058, 1'b0, 32'h55, 0);
    check("dual_hit1", o1_hit, 2'b11);
    check("dual_state1", o1_st, 3);
    check("dual_count1", o1_cnt, 1);
    check("dual_hit0", o0_hit, 2'b11);
    $display("[TB] txn: dual match, hit1=%b state1=%0d", o1_hit, o1_st);

    // watchdog
    match_en = 2'b00;
    pulse_arm();
    repeat (19) tick();
    check("wd_state0_before", o0_st, 1);
    check("wd_to0_before", o0_to, 0);
    tick();
    check("wd_state0_fired", o0_st, 3);
    check("wd_to0_fired", o0_to, 1);
    check("wd_state1_disabled", o1_st, 1);
    pulse_arm();
    check("wd_to0_cleared", o0_to, 0);
    check("wd_state0_rearmed", o0_st, 1);
    $display("[TB] txn: watchdog fired and cleared");

    // wait-stated read
    pulse_arm();
    HTRANS = 2'b10; HADDR = 32'h40; HWRITE = 1'b0; HREADY = 1'b1;
    tick();
    HTRANS = 2'b00; HREADY = 1'b0;
    repeat (3) tick();
    HREADY = 1'b1; HRDATA = 32'hDEAD; exp_stamp = m_cycle[15:0];
    tick();
    check("ws_count0", o0_cnt, 1);
    read0(3'd0);
    check("ws_data0", o0_rd, 32'hDEAD);
    check("ws_write0", o0_rw, 0);
    check("ws_stamp0", o0_rs, exp_stamp);
    $display("[TB] txn: wait-state read data=%h stamp=%h", o0_rd, o0_rs);

    // asynchronous reset during a pending transfer
    HTRANS = 2'b10; HADDR = 32'h44; HREADY = 1'b1;
    tick();
    HTRANS = 2'b00; HREADY = 1'b0;
    tick();
    #2 HRESETn = 1'b0;
    #1;
    check("ar_state0", o0_st, 0);
    check("ar_count0", o0_cnt, 0);
    check("ar_cycle0", o0_cyc, 0);
    check("ar_rd_data0", o0_rd, 0);
    check("ar_rd_stamp0", o0_rs, 0);
    check("ar_count1", o1_cnt, 0);
    HREADY = 1'b1;
    tick(); tick();
    HRESETn = 1'b1;
    tick();
    $display("[TB] txn: async reset mid-wait");

    // randomized traffic
    match_addr = {32'h80000040, 32'h1fc00058}; match_en = 2'b11;
    quiet = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) quiet = 30;
      arm    = ($urandom_range(0, 79) == 0);
      HTRANS = (arm || quiet > 0) ? 2'b00 : 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) HADDR = $urandom_range(0, 1) ? 32'h1fc00058 : 32'h80000040;
      else HADDR = 32'($urandom_range(0, 15)) << 2;
      HWRITE = 1'($urandom_range(0, 1));
      HREADY = ($urandom_range(0, 4) != 0);
      HRDATA = $urandom; HWDATA = $urandom;
      rd_en  = 1'($urandom_range(0, 1));
      rd_idx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) match_en = 2'($urandom_range(0, 3));
      if (quiet > 0) quiet--;
      tick();
      if (i % 500 == 499) $display("[TB] txn: random step %0d state0=%0d count0=%0d", i + 1, o0_st, o0_cnt);
    end
    arm = 0; rd_en = 0; HTRANS = 0;
    tick();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
